i2c_target_regs: RTL and testbench

Synthesizable I2C target (slave) with an 8-bit register file, sitting on the far end of the bus from the Nios I2C OpenCores masters. It answers the master's address, write and read transactions so that sensor firmware (light, MPU, RH/temp drivers) can run against an emulated sensor on the DE10-Nano fabric. Local logic loads readable register contents, and the block raises an active-low data-ready interrupt like the real sensors do.

---
 rtl/i2c_target_pkg.sv | 30 +++
 rtl/i2c_line_filter.sv | 48 ++++
 rtl/i2c_target_regs.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg
// Shared types and constants for the I2C register target:
//   state_t - protocol state machine encoding
//   cond_t  - bus condition seen on the filtered lines (none/START/STOP)
//   ACK_BIT / NACK_BIT - SDA level of an acknowledge / not-acknowledge
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    COND_NONE,
    COND_START,
    COND_STOP
  } cond_t;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter
// Two-flop synchronizer followed by a glitch filter for one open-drain line.
// The filtered output only follows the synchronized input once it has held
// the new level for FILTER_LEN consecutive samples, so pad-to-output latency
// is 2+FILTER_LEN clocks.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (output resets to the idle-high level)
//   raw   - asynchronous pad input
//   clean - synchronized, filtered level
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The line is binary, so "differs from clean" on consecutive samples means
  // the same new level on consecutive samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      clean <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs
// I2C target with an 8-bit register file. The master writes a pointer byte
// and then data bytes, or reads from the current pointer with auto-increment.
// Local logic can load registers; a load raises int_n until the master
// addresses the block for a read.
// Ports:
//   clk_clk, reset_reset_n         - clock, asynchronous active-low reset
//   scl_i, sda_i                   - bus pad inputs
//   sda_oe                         - pull SDA low when 1 (open drain)
//   reg_wr_en/addr/data            - local register load
//   i2c_wr_valid/addr/data         - one-cycle report of a master write
//   int_n                          - active-low data-ready interrupt
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = 7'h40,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  input  logic                        reg_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] reg_wr_addr,
  input  logic [7:0]                  reg_wr_data,
  output logic                        i2c_wr_valid,
  output logic [$clog2(NUM_REGS)-1:0] i2c_wr_addr,
  output logic [7:0]                  i2c_wr_data,
  output logic                        int_n
);

  localparam int AW = $clog2(NUM_REGS);

  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall;
  cond_t cond;

  state_t        state, state_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [6:0]    shreg, shreg_next;   // first seven bits of the byte in flight
  logic [6:0]    tx, tx_next;         // remaining bits of the byte being read
  logic [AW-1:0] ptr, ptr_next;
  logic          rw, rw_next;
  logic          sda_oe_next;
  logic          i2c_we;
  logic          int_clear;
  logic [7:0]    rx_byte;
  logic [7:0]    regs [NUM_REGS];

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk_clk), .rst_n(reset_reset_n), .raw(scl_i), .clean(scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk_clk), .rst_n(reset_reset_n), .raw(sda_i), .clean(sda_f)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign rx_byte  = {shreg, sda_f};

  // START/STOP require SCL high both before and after the SDA transition.
  always_comb begin
    cond = COND_NONE;
    if (scl_f && scl_d && sda_d && !sda_f) cond = COND_START;
    else if (scl_f && scl_d && !sda_d && sda_f) cond = COND_STOP;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
      tx      <= tx_next;
      ptr     <= ptr_next;
      rw      <= rw_next;
      sda_oe  <= sda_oe_next;
    end
  end

  // In the three ACK states and RDATA_ACK, bit_cnt is a phase flag:
  // 0 = before the ninth SCL rise, 1 = after it.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    tx_next      = tx;
    ptr_next     = ptr;
    rw_next      = rw;
    sda_oe_next  = sda_oe;
    i2c_we       = 1'b0;
    int_clear    = 1'b0;
    if (cond == COND_STOP) begin
      state_next  = ST_IDLE;
      sda_oe_next = 1'b0;
    end else if (cond == COND_START) begin
      state_next   = ST_ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shreg_next   = rx_byte[6:0];
            bit_cnt_next = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt_next = '0;
              if (state == ST_ADDR) begin
                rw_next = sda_f;
                if (rx_byte[7:1] == I2C_ADDR) begin
                  state_next = ST_ADDR_ACK;
                  int_clear  = sda_f;
                end else begin
                  state_next = ST_IGNORE;
                end
              end else if (state == ST_PTR) begin
                ptr_next   = rx_byte[AW-1:0];
                state_next = ST_PTR_ACK;
              end else begin
                i2c_we     = 1'b1;
                ptr_next   = ptr + 1'b1;
                state_next = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_rise) begin
            bit_cnt_next = 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe_next = 1'b1;
            end else begin
              bit_cnt_next = '0;
              if (state == ST_ADDR_ACK && rw) begin
                state_next  = ST_RDATA;
                tx_next     = regs[ptr][6:0];
                sda_oe_next = ~regs[ptr][7];
              end else begin
                state_next  = (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                sda_oe_next = 1'b0;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bit_cnt_next = '0;
              state_next   = ST_RDATA_ACK;
            end
          end else if (scl_fall) begin
            tx_next     = {tx[5:0], 1'b0};
            sda_oe_next = ~tx[6];
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_f == ACK_BIT) begin
              bit_cnt_next = 3'd1;
              ptr_next     = ptr + 1'b1;
            end else begin
              state_next = ST_IGNORE;
            end
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe_next = 1'b0;
            end else begin
              // Latch the next byte here so local loads mid-byte cannot tear it.
              bit_cnt_next = '0;
              state_next   = ST_RDATA;
              tx_next      = regs[ptr][6:0];
              sda_oe_next  = ~regs[ptr][7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A master write to the same register as a local load takes precedence.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i2c_we && ptr == AW'(i)) regs[i] <= rx_byte;
        else if (reg_wr_en && reg_wr_addr == AW'(i)) regs[i] <= reg_wr_data;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      i2c_wr_valid <= 1'b0;
      i2c_wr_addr  <= '0;
      i2c_wr_data  <= '0;
      int_n        <= 1'b1;
    end else begin
      i2c_wr_valid <= i2c_we;
      if (i2c_we) begin
        i2c_wr_addr <= ptr;
        i2c_wr_data <= rx_byte;
      end
      if (reg_wr_en) int_n <= 1'b0;
      else if (int_clear) int_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs
// Directed bench: the initial block acts as the bus master, bit-banging SCL
// and SDA (wired-AND with the target's sda_oe), and checks acks, read data,
// write reports, int_n and reset behaviour against hand-computed values.
module tb_i2c_target_regs;
  import i2c_target_pkg::*;

  localparam int Q = 10;  // quarter SCL period in clocks

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_i;
  logic       sda_oe;
  logic       reg_wr_en = 1'b0;
  logic [3:0] reg_wr_addr = '0;
  logic [7:0] reg_wr_data = '0;
  logic       i2c_wr_valid;
  logic [3:0] i2c_wr_addr;
  logic [7:0] i2c_wr_data;
  logic       int_n;

  int tests = 0;
  int failures = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  logic [11:0] wr_log [64];

  assign sda_i = sda_m & ~sda_oe;

  i2c_target_regs #(.I2C_ADDR(7'h40), .NUM_REGS(16), .FILTER_LEN(3)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .scl_i(scl_m), .sda_i(sda_i), .sda_oe(sda_oe),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .i2c_wr_valid(i2c_wr_valid), .i2c_wr_addr(i2c_wr_addr),
    .i2c_wr_data(i2c_wr_data), .int_n(int_n)
  );

  always #5 clk_clk = ~clk_clk;

  always @(negedge clk_clk) begin
    if (i2c_wr_valid && wr_cnt < 64) begin
      wr_log[wr_cnt] = {i2c_wr_addr, i2c_wr_data};
      wr_cnt++;
    end
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic local_load(input logic [3:0] a, input logic [7:0] d);
    reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
    tick(1);
    reg_wr_en = 1'b0;
    $display("[TB] local load reg[%0d]=%02h", a, d);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic bit_w(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bit_r(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_i; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic byte_w(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(ack_n);
    $display("[TB] master wrote %02h, ack_n=%0b", d, ack_n);
  endtask

  task automatic byte_r(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
    bit_w(nack);
    $display("[TB] master read %02h, sent %s", d, nack ? "nack" : "ack");
  endtask

  task automatic read_reg(input logic [7:0] p, output logic [7:0] d);
    logic a;
    i2c_start();
    byte_w(8'h80, a);
    byte_w(p, a);
    i2c_start();
    byte_w(8'h81, a);
    byte_r(1'b1, d);
    i2c_stop();
  endtask

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] d0, d1;
    int         base_wr, base_oe;

    // ---- reset state ----
    #2 reset_reset_n = 1'b0;
    #20;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_int_n", int_n, 1'b1);
    check("rst_wr_valid", i2c_wr_valid, 1'b0);
    check("rst_wr_addr", i2c_wr_addr, 4'h0);
    check("rst_wr_data", i2c_wr_data, 8'h00);
    check("rst_state", dut.state, ST_IDLE);
    tick(1);
    reset_reset_n = 1'b1;
    tick(Q);

    // ---- write: 0x80, ptr 3, A5, 5A ----
    base_wr = wr_cnt;
    i2c_start();
    byte_w(8'h80, a0);
    byte_w(8'h03, a1);
    byte_w(8'hA5, a2);
    byte_w(8'h5A, a3);
    i2c_stop();
    check("wr_acks", {a0, a1, a2, a3}, 4'b0000);
    check("wr_count", wr_cnt - base_wr, 2);
    check("wr_first", wr_log[base_wr], {4'h3, 8'hA5});
    check("wr_second", wr_log[base_wr + 1], {4'h4, 8'h5A});
    check("wr_int_n", int_n, 1'b1);

    // ---- combined read with pointer wrap ----
    local_load(4'hF, 8'h11);
    local_load(4'h0, 8'h22);
    tick(1);
    check("ld_int_n", int_n, 1'b0);
    i2c_start();
    byte_w(8'h80, a0);
    byte_w(8'h0F, a1);
    i2c_start();
    byte_w(8'h81, a2);
    check("rd_int_n_clear", int_n, 1'b1);
    byte_r(1'b0, d0);
    byte_r(1'b1, d1);
    i2c_stop();
    check("rd_acks", {a0, a1, a2}, 3'b000);
    check("rd_byte0", d0, 8'h11);
    check("rd_byte1_wrap", d1, 8'h22);

    // ---- wrong address ----
    base_wr = wr_cnt;
    base_oe = oe_cnt;
    i2c_start();
    byte_w(8'h42, a0);
    byte_w(8'h07, a1);
    byte_w(8'hEE, a2);
    i2c_stop();
    check("wa_nack", {a0, a1, a2}, 3'b111);
    check("wa_no_oe", oe_cnt - base_oe, 0);
    check("wa_no_wr", wr_cnt - base_wr, 0);
    read_reg(8'h07, d0);
    check("wa_reg7", d0, 8'h00);

    // ---- int_n across a write, cleared by read addressing ----
    local_load(4'h2, 8'hC3);
    tick(1);
    check("int_ld", int_n, 1'b0);
    base_wr = wr_cnt;
    i2c_start();
    byte_w(8'h80, a0);
    byte_w(8'h01, a1);
    byte_w(8'h99, a2);
    i2c_stop();
    check("int_after_wr", int_n, 1'b0);
    check("int_wr_log", wr_log[base_wr], {4'h1, 8'h99});
    i2c_start();
    check("int_before_rd", int_n, 1'b0);
    byte_w(8'h81, a0);
    check("int_rd_ack", a0, 1'b0);
    check("int_cleared", int_n, 1'b1);
    byte_r(1'b1, d0);
    i2c_stop();
    check("int_rd_data", d0, 8'hC3);

    // ---- glitch filtering ----
    tick(Q);
    sda_m = 1'b0; tick(1);
    sda_m = 1'b1; tick(10);
    check("glitch_state", dut.state, ST_IDLE);
    for (int i = 7; i >= 0; i--) bit_w(logic'(i == 7));
    bit_r(a0);
    check("glitch_no_ack", a0, 1'b1);
    i2c_stop();
    tick(Q);
    sda_m = 1'b0; tick(4);
    sda_m = 1'b1; tick(3);
    check("long_pulse_start", dut.state, ST_ADDR);
    tick(5);
    check("long_pulse_stop", dut.state, ST_IDLE);

    // ---- reset mid-RDATA ----
    local_load(4'h5, 8'h00);
    i2c_start();
    byte_w(8'h80, a0);
    byte_w(8'h05, a1);
    i2c_start();
    byte_w(8'h81, a2);
    check("mid_rd_oe", sda_oe, 1'b1);
    #3 reset_reset_n = 1'b0;
    #1;
    check("mid_rst_oe", sda_oe, 1'b0);
    check("mid_rst_state", dut.state, ST_IDLE);
    tick(2);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(Q);
    reset_reset_n = 1'b1;
    tick(Q);
    $display("[TB] reset applied mid-read");

    // ---- normal operation after reset ----
    read_reg(8'h03, d0);
    check("post_rst_reg3", d0, 8'h00);
    base_wr = wr_cnt;
    i2c_start();
    byte_w(8'h80, a0);
    byte_w(8'h07, a1);
    byte_w(8'h3C, a2);
    i2c_stop();
    check("post_wr_acks", {a0, a1, a2}, 3'b000);
    check("post_wr_log", wr_log[base_wr], {4'h7, 8'h3C});
    read_reg(8'h07, d0);
    check("post_rd", d0, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
